// File: rtl/bob_pkg.sv
// Shared BOB ring parameters and pointer type.
// Used by the pointer controller, the BOB RAM and the branch unit so that all
// three agree on ring depth and pointer width.
package bob_pkg;

  localparam int BOB_DEPTH     = 63;
  localparam int BOB_ADDR_W    = 6;
  localparam int BOB_CNT_W     = BOB_ADDR_W + 1;
  localparam int BOB_ALLOC_MAX = 2;
  localparam int BOB_RET_MAX   = 2;

  typedef logic [BOB_ADDR_W-1:0] bob_ptr_t;

endpackage

// File: rtl/bob_ptr_add.sv
// Modular pointer adder for a ring of arbitrary (non power-of-two) depth.
// Ports:
//   ptr  in  ADDR_W  current pointer, always < DEPTH
//   inc  in  INC_W   increment, small (at most one wrap possible)
//   sum  out ADDR_W  (ptr + inc) mod DEPTH
module bob_ptr_add #(
  parameter int DEPTH  = 63,
  parameter int ADDR_W = 6,
  parameter int INC_W  = 2
) (
  input  logic [ADDR_W-1:0] ptr,
  input  logic [INC_W-1:0]  inc,
  output logic [ADDR_W-1:0] sum
);

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W:0] raw;

  // One extra bit holds the carry; a single conditional subtract is enough
  // because ptr < DEPTH and inc <= DEPTH.
  assign raw = {1'b0, ptr} + (ADDR_W+1)'(inc);
  assign sum = (raw >= DEPTH_X) ? ADDR_W'(raw - DEPTH_X) : raw[ADDR_W-1:0];

endmodule

// File: rtl/bob_ptr_ctl.sv
// Pointer / occupancy controller for the branch-order buffer ring.
// Tracks the allocation pointer, the retire pointer and the live-entry count,
// and handles exception flush and mispredict rollback.
// Ports:
//   clk          in   clock
//   rst          in   asynchronous reset, active low
//   flush        in   discard all live entries
//   rb_en        in   rollback request; entries younger than rb_addr are dropped
//   rb_addr      in   mispredicted branch entry (kept)
//   alloc_cnt    in   entries requested this cycle
//   stall        in   external allocation stall
//   alloc_addr   out  first entry of the current allocation
//   doStall      out  fewer than ALLOC_MAX free entries (registered count only)
//   retire_cnt   in   retires requested
//   retire_take  out  retires granted this cycle (combinational)
//   hasRetire    out  at least one live entry
//   retire_addr  out  retire pointer for the next cycle, feeds RAM read address
//   used         out  live entry count
//   free         out  DEPTH - used
module bob_ptr_ctl
  import bob_pkg::*;
#(
  parameter int  DEPTH     = BOB_DEPTH,
  parameter int  ADDR_W    = BOB_ADDR_W,
  parameter int  CNT_W     = ADDR_W + 1,
  parameter int  ALLOC_MAX = BOB_ALLOC_MAX,
  parameter int  RET_MAX   = BOB_RET_MAX,
  localparam int AC_W      = $clog2(ALLOC_MAX + 1),
  localparam int RC_W      = $clog2(RET_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              rb_en,
  input  logic [ADDR_W-1:0] rb_addr,
  input  logic [AC_W-1:0]   alloc_cnt,
  input  logic              stall,
  output logic [ADDR_W-1:0] alloc_addr,
  output logic              doStall,
  input  logic [RC_W-1:0]   retire_cnt,
  output logic [RC_W-1:0]   retire_take,
  output logic              hasRetire,
  output logic [ADDR_W-1:0] retire_addr,
  output logic [CNT_W-1:0]  used,
  output logic [CNT_W-1:0]  free
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] ret_ptr_q, ret_ptr_d;
  logic [ADDR_W-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [CNT_W-1:0]  used_q, used_d;

  logic [CNT_W-1:0]  free_w;
  logic              do_stall;
  logic              alloc_ok;
  logic [AC_W-1:0]   alloc_inc;
  logic [RC_W-1:0]   take;
  logic [ADDR_W-1:0] alloc_adv;
  logic [ADDR_W-1:0] ret_adv;
  logic [ADDR_W-1:0] rb_next;
  logic [CNT_W-1:0]  rb_dist;

  // Stall is a function of the registered count only, so the same-cycle
  // retire never feeds back into the allocation handshake.
  assign free_w   = DEPTH_C - used_q;
  assign do_stall = free_w < CNT_W'(ALLOC_MAX);

  assign alloc_ok  = (alloc_cnt != '0) && !stall && !do_stall && !flush && !rb_en;
  assign alloc_inc = alloc_ok ? alloc_cnt : '0;

  always_comb begin
    take = '0;
    if (!flush && !rb_en) begin
      if (CNT_W'(retire_cnt) <= used_q) take = retire_cnt;
      else                               take = RC_W'(used_q);
    end
  end

  bob_ptr_add #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INC_W(AC_W)) u_alloc_add (
    .ptr (alloc_ptr_q),
    .inc (alloc_inc),
    .sum (alloc_adv)
  );

  bob_ptr_add #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INC_W(RC_W)) u_ret_add (
    .ptr (ret_ptr_q),
    .inc (take),
    .sum (ret_adv)
  );

  bob_ptr_add #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INC_W(1)) u_rb_add (
    .ptr (rb_addr),
    .inc (1'b1),
    .sum (rb_next)
  );

  // Distance from the oldest live entry to the rollback target, mod DEPTH.
  always_comb begin
    if (rb_addr >= ret_ptr_q) rb_dist = CNT_W'(rb_addr) - CNT_W'(ret_ptr_q);
    else                      rb_dist = DEPTH_C - CNT_W'(ret_ptr_q) + CNT_W'(rb_addr);
  end

  always_comb begin
    ret_ptr_d   = ret_ptr_q;
    alloc_ptr_d = alloc_ptr_q;
    used_d      = used_q;
    if (flush) begin
      ret_ptr_d = alloc_ptr_q;
      used_d    = '0;
    end else if (rb_en) begin
      alloc_ptr_d = rb_next;
      used_d      = rb_dist + CNT_W'(1);
    end else begin
      alloc_ptr_d = alloc_adv;
      ret_ptr_d   = ret_adv;
      used_d      = used_q + CNT_W'(alloc_inc) - CNT_W'(take);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ret_ptr_q   <= '0;
      alloc_ptr_q <= '0;
      used_q      <= '0;
    end else begin
      ret_ptr_q   <= ret_ptr_d;
      alloc_ptr_q <= alloc_ptr_d;
      used_q      <= used_d;
    end
  end

  // Lookahead read address: the RAM registers this on the same edge that
  // updates ret_ptr, so read data lines up with the new retire pointer.
  always_comb begin
    if (!rst)       retire_addr = '0;
    else if (flush) retire_addr = alloc_ptr_q;
    else if (rb_en) retire_addr = ret_ptr_q;
    else            retire_addr = ret_adv;
  end

  assign alloc_addr  = alloc_ptr_q;
  assign retire_take = take;
  assign hasRetire   = (used_q != '0);
  assign used        = used_q;
  assign free        = free_w;
  assign doStall     = do_stall;

endmodule

// File: tb/tb_bob_ptr_ctl.sv
module tb_bob_ptr_ctl;
  import bob_pkg::*;

  localparam int DEPTH     = 63;
  localparam int ALLOC_MAX = 2;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       rb_en;
  bob_ptr_t   rb_addr;
  logic [1:0] alloc_cnt;
  logic       stall;
  bob_ptr_t   alloc_addr;
  logic       doStall;
  logic [1:0] retire_cnt;
  logic [1:0] retire_take;
  logic       hasRetire;
  bob_ptr_t   retire_addr;
  logic [6:0] used;
  logic [6:0] free;

  int checks = 0;
  int errors = 0;

  bob_ptr_ctl #(
    .DEPTH(63), .ADDR_W(6), .CNT_W(7), .ALLOC_MAX(2), .RET_MAX(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .rb_en       (rb_en),
    .rb_addr     (rb_addr),
    .alloc_cnt   (alloc_cnt),
    .stall       (stall),
    .alloc_addr  (alloc_addr),
    .doStall     (doStall),
    .retire_cnt  (retire_cnt),
    .retire_take (retire_take),
    .hasRetire   (hasRetire),
    .retire_addr (retire_addr),
    .used        (used),
    .free        (free)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Model: the ring as an ordered list of live entry indices (oldest first)
  // plus the index the next allocation will receive.
  int live[$];
  int nxt = 0;

  function automatic int m_take(int rc, bit fl, bit rb);
    if (fl || rb) return 0;
    return (rc < live.size()) ? rc : live.size();
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      live.delete();
      nxt = 0;
    end else if (flush) begin
      live.delete();
    end else if (rb_en) begin
      int idx;
      idx = -1;
      foreach (live[i]) if (live[i] == int'(rb_addr)) idx = i;
      assert (idx >= 0) else $error("rollback target %0d not live", rb_addr);
      while (live.size() > idx + 1) void'(live.pop_back());
      nxt = (int'(rb_addr) + 1) % DEPTH;
    end else begin
      int t;
      bit acc;
      t   = m_take(int'(retire_cnt), 1'b0, 1'b0);
      acc = (alloc_cnt != 2'd0) && !stall && ((DEPTH - live.size()) >= ALLOC_MAX);
      repeat (t) void'(live.pop_front());
      if (acc) begin
        repeat (int'(alloc_cnt)) begin
          live.push_back(nxt);
          nxt = (nxt + 1) % DEPTH;
        end
      end
    end
  end

  always @(negedge clk) begin
    int u, t, ra;
    u = live.size();
    t = m_take(int'(retire_cnt), flush, rb_en);
    if (!rst)       ra = 0;
    else if (flush) ra = nxt;
    else if (rb_en) ra = (u > 0) ? live[0] : nxt;
    else            ra = (t < u) ? live[t] : nxt;
    chk("cmp_used",        int'(used),        u);
    chk("cmp_free",        int'(free),        DEPTH - u);
    chk("cmp_doStall",     int'(doStall),     int'((DEPTH - u) < ALLOC_MAX));
    chk("cmp_hasRetire",   int'(hasRetire),   int'(u != 0));
    chk("cmp_alloc_addr",  int'(alloc_addr),  nxt);
    chk("cmp_retire_take", int'(retire_take), t);
    chk("cmp_retire_addr", int'(retire_addr), ra);
  end

  task automatic drive(int ac, int rc, bit st, bit fl, bit rb, int rba);
    alloc_cnt  = 2'(ac);
    retire_cnt = 2'(rc);
    stall      = st;
    flush      = fl;
    rb_en      = rb;
    rb_addr    = 6'(rba);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_used",        int'(used),        0);
    chk("rst_free",        int'(free),        63);
    chk("rst_retire_addr", int'(retire_addr), 0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    tick();
    chk("init_doStall",   int'(doStall),   0);
    chk("init_hasRetire", int'(hasRetire), 0);

    // full ring
    drive(2, 0, 0, 0, 0, 0);
    repeat (31) tick();
    chk("full_used",       int'(used),       62);
    chk("full_free",       int'(free),       1);
    chk("full_doStall",    int'(doStall),    1);
    chk("full_alloc_addr", int'(alloc_addr), 62);
    tick();
    chk("full_hold_used",  int'(used),       62);
    chk("full_hold_addr",  int'(alloc_addr), 62);

    // drain to ret_ptr=60, then allocate across the wrap
    drive(0, 2, 0, 0, 0, 0);
    repeat (30) tick();
    chk("drain_used", int'(used), 2);
    drive(2, 0, 0, 0, 0, 0);
    #1;
    chk("wrap_retire_addr", int'(retire_addr), 60);
    tick();
    chk("wrap_alloc_addr", int'(alloc_addr), 1);
    chk("wrap_used",       int'(used),       4);

    // rollback onto entry 62: next allocation wraps to 0
    drive(0, 0, 0, 0, 1, 62);
    #1;
    chk("rbwrap_retire_addr", int'(retire_addr), 60);
    tick();
    chk("rbwrap_used",       int'(used),       3);
    chk("rbwrap_alloc_addr", int'(alloc_addr), 0);

    // rollback with simultaneous alloc and retire requests
    do_reset();
    drive(2, 0, 0, 0, 0, 0);
    repeat (5) tick();
    drive(0, 2, 0, 0, 0, 0);
    tick();
    drive(2, 1, 0, 0, 1, 5);
    #1;
    chk("rb_retire_take", int'(retire_take), 0);
    chk("rb_retire_addr", int'(retire_addr), 2);
    tick();
    chk("rb_alloc_addr", int'(alloc_addr), 6);
    chk("rb_used",       int'(used),       4);

    // flush wins over rollback
    drive(2, 2, 0, 1, 1, 3);
    #1;
    chk("flrb_retire_addr", int'(retire_addr), 6);
    chk("flrb_retire_take", int'(retire_take), 0);
    tick();
    chk("flrb_used",       int'(used),       0);
    chk("flrb_alloc_addr", int'(alloc_addr), 6);

    // flush
    do_reset();
    drive(2, 0, 0, 0, 0, 0);
    repeat (5) tick();
    drive(0, 2, 0, 0, 0, 0);
    tick();
    drive(0, 1, 0, 0, 0, 0);
    tick();
    chk("pre_flush_used", int'(used), 7);
    drive(0, 0, 0, 1, 0, 0);
    #1;
    chk("flush_retire_addr", int'(retire_addr), 10);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("flush_used",       int'(used),       0);
    chk("flush_hasRetire",  int'(hasRetire),  0);
    chk("flush_alloc_addr", int'(alloc_addr), 10);

    // retire clamp
    drive(1, 0, 0, 0, 0, 0);
    tick();
    chk("lat_hasRetire", int'(hasRetire), 1);
    drive(1, 2, 0, 0, 0, 0);
    #1;
    chk("clamp_take",        int'(retire_take), 1);
    chk("clamp_retire_addr", int'(retire_addr), 11);
    tick();
    chk("clamp_used",       int'(used),       1);
    chk("clamp_alloc_addr", int'(alloc_addr), 12);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("clamp_ret_ptr", int'(retire_addr), 11);

    // external stall blocks allocation
    drive(2, 0, 1, 0, 0, 0);
    tick();
    chk("stall_alloc_addr", int'(alloc_addr), 12);
    chk("stall_used",       int'(used),       1);

    // async reset between edges
    do_reset();
    drive(2, 0, 0, 0, 0, 0);
    repeat (10) tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("pre_arst_used", int'(used), 20);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_used",        int'(used),        0);
    chk("arst_alloc_addr",  int'(alloc_addr),  0);
    chk("arst_retire_addr", int'(retire_addr), 0);
    chk("arst_free",        int'(free),        63);
    @(posedge clk);
    #3;
    rst = 1'b1;
    drive(1, 0, 0, 0, 0, 0);
    #1;
    chk("post_arst_alloc_addr", int'(alloc_addr), 0);
    tick();
    chk("post_arst_next_addr", int'(alloc_addr), 1);
    chk("post_arst_used",      int'(used),       1);
    drive(0, 0, 0, 0, 0, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bob_ptr_ctl.md
# bob_ptr_ctl

Parametrised pointer/occupancy controller for the branch-order buffer (BOB) ring.
- Allocates up to ALLOC_MAX consecutive entries and retires up to RET_MAX entries per cycle.
- Supports full flush on exception and partial rollback on branch mispredict.
- Depth is arbitrary, not necessarily a power of two.
- Sits between rename/branch-issue and the BOB RAM. It drives the RAM write address and provides a one-cycle-lookahead read address for retire.

## Interface

Parameters:
- DEPTH, 63: ring entries; pointers wrap from DEPTH-1 to 0.
- ADDR_W, 6: pointer width; DEPTH ≤ 2^ADDR_W.
- CNT_W, ADDR_W+1: occupancy counter width.
- ALLOC_MAX, 2: maximum allocations per cycle.
- RET_MAX, 2: maximum retires per cycle.

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  exception: discard all live entries.
- rb_en  in  1  mispredict rollback request.
- rb_addr  in  ADDR_W  mispredicted branch entry; this entry is kept, all younger entries are discarded.
- alloc_cnt  in  clog2(ALLOC_MAX+1)  entries requested this cycle.
- stall  in  1  external allocation stall.
- alloc_addr  out  ADDR_W  first entry of the current allocation; entries run alloc_addr..alloc_addr+alloc_cnt-1 mod DEPTH.
- doStall  out  1  free < ALLOC_MAX.
- retire_cnt  in  clog2(RET_MAX+1)  retires requested.
- retire_take  out  clog2(RET_MAX+1)  retires granted this cycle.
- hasRetire  out  1  used != 0.
- retire_addr  out  ADDR_W  next-cycle retire pointer (combinational), for RAM read_addr.
- used  out  CNT_W  live entry count.
- free  out  CNT_W  DEPTH-used.

## Operation

State:
- ret_ptr, alloc_ptr, used (registers).
- alloc_addr = alloc_ptr.

Allocation:
- Accepted when alloc_cnt != 0, !stall, !doStall, !flush and !rb_en.
- On acceptance, alloc_ptr += alloc_cnt mod DEPTH.
- A rejected request is dropped; the requester holds and retries.

Retire:
- retire_take = min(retire_cnt, used).
- retire_take is 0 when flush or rb_en is asserted.
- ret_ptr += retire_take mod DEPTH.

Count:
- used_next = used + accepted_alloc - retire_take in the normal case.
- Alloc and retire in the same cycle net out.

Flush (priority over rollback and normal operation):
- ret_ptr := alloc_ptr.
- used := 0.
- alloc_ptr unchanged.

Rollback (when flush is low):
- alloc_ptr := rb_addr+1 mod DEPTH.
- used := ((rb_addr - ret_ptr) mod DEPTH) + 1.
- ret_ptr unchanged.
- rb_addr must lie in the live range; a rollback outside it is a protocol error (assertion in bench).

retire_addr, by priority:
- 0 while rst is low.
- alloc_ptr when flush.
- ret_ptr when rb_en.
- ret_ptr+retire_take mod DEPTH otherwise.

Modular add:
- Operands are < DEPTH and the increment is ≤ max(ALLOC_MAX, RET_MAX).
- Result = sum ≥ DEPTH ? sum-DEPTH : sum. No power-of-two masking.

Never reachable: used > DEPTH, or alloc/retire that overflow or underflow the ring.

## Timing

- Reset (rst low, asynchronous): ret_ptr=0, alloc_ptr=0, used=0.
- Outputs during and after reset: alloc_addr=0, retire_addr=0, used=0, free=DEPTH, hasRetire=0, doStall=0 (for ALLOC_MAX ≤ DEPTH), retire_take=0.
- Reset asserted mid-cycle clears all state immediately. Nothing is allocated or retired on the releasing edge.
- Register updates (alloc_addr, used, free, hasRetire, doStall) take effect the cycle after the request edge.
- retire_take and retire_addr are combinational in the request cycle. The BOB RAM registers retire_addr on the same edge, so read data appears the following cycle.
- doStall is derived only from the registered used; it is never combinational on the same cycle's retire.
- Latency: an entry allocated at edge N is retirable (hasRetire=1) from cycle N+1.

## Structure

- Shared package (bob_pkg): DEPTH, ADDR_W, CNT_W defaults, ALLOC_MAX, RET_MAX, and a bob_ptr_t typedef. These are shared with the BOB RAM and the branch unit.
- Sub-module bob_ptr_add: parametrised modular adder (ptr, inc) → (ptr+inc) mod DEPTH.
- Three bob_ptr_add instances: alloc advance, retire advance, rollback +1.
- Rollback distance: a separate modular subtract, inline.

## Test plan

All scenarios use DEPTH=63, ALLOC_MAX=2, RET_MAX=2.

1. Full ring: from reset, alloc_cnt=2 for 31 cycles with no retire → used=62, free=1, doStall=1, alloc_addr=62. A further alloc_cnt=2 is ignored; state is unchanged.
2. Wrap: ret_ptr=60, alloc_ptr=62, used=2; alloc_cnt=2 → entries 62,0 allocated, alloc_addr=1, used=4.
3. Rollback with retire and alloc in the same cycle: ret_ptr=2, alloc_ptr=10, rb_en=1, rb_addr=5, alloc_cnt=2, retire_cnt=1 → retire_take=0, retire_addr=2, next alloc_addr=6, used=4.
4. Flush: ret_ptr=3, alloc_ptr=10, flush=1 → retire_addr=10 the same cycle; next cycle used=0, hasRetire=0, alloc_addr=10.
5. Retire clamp: used=1, retire_cnt=2, alloc_cnt=1 → retire_take=1, used stays 1, ret_ptr advances by 1.
6. Async reset mid-operation: used=20, rst driven low between edges → used=0, alloc_addr=0, retire_addr=0 with no clock edge. After release, the first alloc_cnt=1 returns alloc_addr=0.
